// File: rtl/fnn_pkg.sv
// Shared definitions for the output layer: data width, default neuron count,
// controller state encoding and the unsigned-byte saturation helper.
package fnn_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned N_OUT_DEFAULT = 10;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StStore,
    StDone
  } state_e;

  // Clamp a signed value into the 0..255 range of an output score.
  function automatic logic [DATA_W-1:0] sat(input logic signed [31:0] r);
    if (r < 0) begin
      return '0;
    end else if (r > 32'sd255) begin
      return '1;
    end else begin
      return r[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/output_layer_if.sv
// Bundle of start/score handshake and weight-memory read port for output_layer.
interface output_layer_if
  import fnn_pkg::*;
#(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = N_OUT_DEFAULT,
  parameter int unsigned AW    = $clog2(N_OUT * (N_IN + 1))
);

  logic                      start;
  logic [DATA_W*N_IN-1:0]    in_data;
  logic [AW-1:0]             w_addr;
  logic [DATA_W-1:0]         w_data;
  logic                      busy;
  logic                      valid;
  logic [DATA_W*N_OUT-1:0]   out;

  modport master (
    output start,
    output in_data,
    output w_data,
    input  w_addr,
    input  busy,
    input  valid,
    input  out
  );

  modport slave (
    input  start,
    input  in_data,
    input  w_data,
    output w_addr,
    output busy,
    output valid,
    output out
  );

endinterface

// File: rtl/mac_unit.sv
// Signed weight x unsigned activation multiply-accumulate with first-term replace
// and an optional pre-shifted bias term.
module mac_unit #(
  parameter int unsigned ACC_W = 21,
  parameter int unsigned SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    first_i,
  input  logic                    bias_i,
  input  logic signed [7:0]       w_i,
  input  logic [7:0]              x_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    prod = 17'(w_i) * 17'($signed({1'b0, x_i}));
    // Bias words enter at the same scale as the products after the final shift.
    if (bias_i) begin
      term = ACC_W'(w_i) <<< SHIFT;
    end else begin
      term = ACC_W'(prod);
    end
    sum_o = first_i ? term : acc_q + term;
    acc_d = en_i ? sum_o : acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/output_layer.sv
// Fully connected output layer: N_OUT neurons over N_IN bytes, one weight per cycle.
// Define OUTPUT_LAYER_BIAS_EN to fetch a per-neuron bias word after the weights.
module output_layer
  import fnn_pkg::*;
#(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = N_OUT_DEFAULT,
  parameter int unsigned SHIFT = 7
) (
  input logic           clk,
  input logic           rst,
  output_layer_if.slave bus
);

  localparam int unsigned AW    = $clog2(N_OUT * (N_IN + 1));
  localparam int unsigned ACC_W = 16 + $clog2(N_IN) + 1;
`ifdef OUTPUT_LAYER_BIAS_EN
  localparam int unsigned N_WORDS = N_IN + 1;
`else
  localparam int unsigned N_WORDS = N_IN;
`endif
  localparam int unsigned IW  = $clog2(N_WORDS + 1);
  localparam int unsigned IPW = $clog2(N_IN);
  localparam int unsigned JW  = $clog2(N_OUT);

  state_e                    state_q, state_d;
  logic [JW-1:0]             j_q, j_d;
  logic [IW-1:0]             i_q, i_d;
  logic [IPW-1:0]            ip_q, ip_d;
  logic [DATA_W*N_IN-1:0]    in_buf_q, in_buf_d;
  logic [AW-1:0]             w_addr_q, w_addr_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic [DATA_W*N_OUT-1:0]   out_q, out_d;
  logic [DATA_W*N_OUT-1:0]   stage_q, stage_d;
  logic                      pv_q, pv_d;
  logic                      first_q, first_d;
  logic                      bias_q, bias_d;

  logic [DATA_W-1:0]         act;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   r;

  function automatic logic [AW-1:0] addr_of(input int unsigned j, input int unsigned i);
    return AW'(j * N_WORDS + i);
  endfunction

  assign act = in_buf_q[DATA_W*ip_q +: DATA_W];
  assign r   = sum >>> SHIFT;

  mac_unit #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .en_i    (pv_q),
    .first_i (first_q),
    .bias_i  (bias_q),
    .w_i     (bus.w_data),
    .x_i     (act),
    .sum_o   (sum)
  );

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    i_d      = i_q;
    ip_d     = ip_q;
    in_buf_d = in_buf_q;
    w_addr_d = w_addr_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    out_d    = out_q;
    stage_d  = stage_q;
    pv_d     = 1'b0;
    first_d  = 1'b0;
    bias_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          in_buf_d = bus.in_data;
          busy_d   = 1'b1;
          j_d      = '0;
          i_d      = '0;
          w_addr_d = addr_of(0, 0);
          state_d  = StMac;
        end
      end
      StMac: begin
        // Tag the word on w_addr so it is consumed when w_data arrives next cycle.
        pv_d    = 1'b1;
        first_d = (i_q == '0);
        ip_d    = i_q[IPW-1:0];
`ifdef OUTPUT_LAYER_BIAS_EN
        bias_d  = (i_q == IW'(N_IN));
`endif
        if (i_q == IW'(N_WORDS - 1)) begin
          state_d = StStore;
        end else begin
          i_d      = i_q + 1'b1;
          w_addr_d = addr_of(int'(j_q), int'(i_q) + 1);
        end
      end
      StStore: begin
        stage_d[DATA_W*j_q +: DATA_W] = sat(32'(r));
        if (j_q == JW'(N_OUT - 1)) begin
          state_d = StDone;
        end else begin
          j_d      = j_q + 1'b1;
          i_d      = '0;
          w_addr_d = addr_of(int'(j_q) + 1, 0);
          state_d  = StMac;
        end
      end
      StDone: begin
        out_d   = stage_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      j_q      <= '0;
      i_q      <= '0;
      ip_q     <= '0;
      in_buf_q <= '0;
      w_addr_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      stage_q  <= '0;
      pv_q     <= 1'b0;
      first_q  <= 1'b0;
      bias_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      i_q      <= i_d;
      ip_q     <= ip_d;
      in_buf_q <= in_buf_d;
      w_addr_q <= w_addr_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      stage_q  <= stage_d;
      pv_q     <= pv_d;
      first_q  <= first_d;
      bias_q   <= bias_d;
    end
  end

  assign bus.w_addr = w_addr_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.out    = out_q;

endmodule

// File: tb/tb_output_layer.sv
// Scoreboard bench for output_layer; expected score vectors queued at launch,
// popped when valid pulses. Honours OUTPUT_LAYER_BIAS_EN for weight layout and latency.
module tb_output_layer;
  import fnn_pkg::*;

  localparam int unsigned N_IN  = 16;
  localparam int unsigned N_OUT = 10;
  localparam int unsigned SHIFT = 7;
`ifdef OUTPUT_LAYER_BIAS_EN
  localparam int unsigned STRIDE = N_IN + 1;
`else
  localparam int unsigned STRIDE = N_IN;
`endif
  localparam int unsigned LAT = N_OUT * (STRIDE + 1) + 1;

  typedef logic [8*N_OUT-1:0] out_t;
  typedef logic [8*N_IN-1:0]  in_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  output_layer #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .SHIFT (SHIFT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] wmem [0:255];
  always @(posedge clk) bus.w_data <= wmem[bus.w_addr];

  out_t exp_q [$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_w();
    for (int a = 0; a < 256; a++) wmem[a] = 8'h00;
  endtask

  function automatic out_t model(input in_t din);
    out_t e;
    e = '0;
    for (int j = 0; j < N_OUT; j++) begin
      int acc;
      int rr;
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        acc += int'($signed(wmem[j*STRIDE+i])) * int'(din[8*i +: 8]);
      end
`ifdef OUTPUT_LAYER_BIAS_EN
      acc += int'($signed(wmem[j*STRIDE+N_IN])) * (1 << SHIFT);
`endif
      rr = acc >>> SHIFT;
      e[8*j +: 8] = (rr < 0) ? 8'd0 : (rr > 255) ? 8'd255 : 8'(rr);
    end
    return e;
  endfunction

  task automatic launch(input in_t din, input out_t exp, input bit hammer);
    @(negedge clk);
    bus.in_data = din;
    bus.start   = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (!hammer) bus.start = 1'b0;
    check_eq("busy_set", bus.busy, 1);
  endtask

  task automatic finish_run(input string tag, input bit hammer);
    out_t held;
    out_t exp;
    int   n;
    int   unstable;
    int   extra;
    bit   seen;
    held     = bus.out;
    n        = 0;
    unstable = 0;
    seen     = 1'b0;
    while (!seen && n < LAT + 20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.valid) begin
        seen = 1'b1;
      end else begin
        if (bus.out !== held) unstable++;
        if (hammer) bus.in_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    bus.start = 1'b0;
    exp = exp_q.pop_front();
    check_eq({tag, "_seen"}, seen, 1);
    check_eq({tag, "_lat"}, n, LAT);
    check_eq({tag, "_out"}, bus.out, exp);
    check_eq({tag, "_busy_low"}, bus.busy, 0);
    check_eq({tag, "_hold"}, unstable, 0);
    extra = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.valid) extra++;
    end
    check_eq({tag, "_one_pulse"}, extra, 0);
    check_eq({tag, "_out_kept"}, bus.out, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    in_t  din;
    out_t e;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.in_data = '0;
    clear_w();
    #2;
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_valid", bus.valid, 0);
    check_eq("rst_out", bus.out, 0);
    check_eq("rst_waddr", bus.w_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // All-zero weights give all-zero scores for any activations.
    din = {$urandom, $urandom, $urandom, $urandom};
    launch(din, '0, 1'b0);
    finish_run("zero_w", 1'b0);

    // Uniform activations of 64 with neuron j weighted j: score 8j.
    clear_w();
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) wmem[j*STRIDE+i] = 8'(j);
    e = '0;
    for (int j = 0; j < N_OUT; j++) e[8*j +: 8] = 8'(8 * j);
    launch({N_IN{8'd64}}, e, 1'b0);
    finish_run("ramp", 1'b0);

    // Saturation both ways.
    clear_w();
    for (int j = 0; j < N_OUT; j++)
      for (int i = 0; i < N_IN; i++) wmem[j*STRIDE+i] = (j == 4) ? 8'd127 : 8'h80;
    e = '0;
    e[8*4 +: 8] = 8'd255;
    launch({N_IN{8'd255}}, e, 1'b0);
    finish_run("sat", 1'b0);

    // Random weights and activations against the reference model.
    for (int a = 0; a < 256; a++) wmem[a] = 8'($urandom);
    din = {$urandom, $urandom, $urandom, $urandom};
    launch(din, model(din), 1'b0);
    finish_run("rand", 1'b0);

    // Start held high and activations churned throughout the run.
    din = {$urandom, $urandom, $urandom, $urandom};
    launch(din, model(din), 1'b1);
    finish_run("hammer", 1'b1);

    // Abort mid-inference, then a clean run with fresh data.
    din = {$urandom, $urandom, $urandom, $urandom};
    launch(din, model(din), 1'b0);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("abort_out", bus.out, 0);
    check_eq("abort_busy", bus.busy, 0);
    check_eq("abort_valid", bus.valid, 0);
    check_eq("abort_waddr", bus.w_addr, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 256; a++) wmem[a] = 8'($urandom);
    din = {$urandom, $urandom, $urandom, $urandom};
    launch(din, model(din), 1'b0);
    finish_run("post_abort", 1'b0);

`ifdef OUTPUT_LAYER_BIAS_EN
    clear_w();
    wmem[2*STRIDE+N_IN] = 8'd5;
    e = '0;
    e[8*2 +: 8] = 8'd5;
    launch({$urandom, $urandom, $urandom, $urandom}, e, 1'b0);
    finish_run("bias", 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/output_layer.md
OUTPUT_LAYER -- requirements
Module: output_layer

Interface
REQ-001 Parameters SHALL be: N_IN, 16, hidden activations per inference; N_OUT, 10, output neurons; SHIFT, 7, accumulator right-shift before saturation.
REQ-002 Ports SHALL be, clock and reset first:
  clk  input  1  single clock, rising edge
  rst  input  1  asynchronous, active-high reset
  start  input  1  request one inference; sampled only in IDLE
  in_data  input  8*N_IN  hidden activations, unsigned 8-bit, activation i at [8i+7:8i]
  w_addr  output  clog2(N_OUT*(N_IN+1))  weight memory read address
  w_data  input  8  signed weight, valid one cycle after w_addr is issued
  busy  output  1  high from start acceptance until the cycle valid rises
  valid  output  1  one-cycle pulse: out updated
  out  output  8*N_OUT  packed unsigned scores, neuron j at [8j+7:8j], feeds the argmax stage
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, MAC, STORE, DONE.
REQ-005 IDLE with start=1 SHALL latch in_data into an internal buffer, set busy, clear neuron index j and input index i, and go to MAC.
REQ-006 MAC SHALL issue w_addr = j*N_IN + i for one cycle per i, for N_IN cycles, then go to STORE.
REQ-007 Each cycle after an address is issued, acc SHALL += signed(w_data) * zero-extended in_buf[i_prev]; the first product of each neuron replaces acc instead of adding.
REQ-008 acc width SHALL be 16 + clog2(N_IN) + 1 bits, signed; no overflow is possible.
REQ-009 STORE SHALL absorb the last product, compute r = acc >>> SHIFT (arithmetic), and write sat(r) into staging byte j, where sat yields 0 if r<0, 255 if r>255, else r.
REQ-010 STORE SHALL go to MAC with j+1 if j<N_OUT-1; otherwise it goes to DONE.
REQ-011 DONE SHALL copy staging to out, pulse valid for one cycle, drop busy, and return to IDLE.
REQ-012 out SHALL hold its previous value throughout an inference and change only in DONE.
REQ-013 Latency SHALL be N_OUT*(N_IN+1)+1 cycles from the start-accept edge to valid high (171 at defaults).
REQ-014 start while busy SHALL be ignored; start sampled in the DONE cycle SHALL be ignored; start in IDLE on the following cycle SHALL be accepted.
REQ-015 in_data changes after acceptance SHALL NOT affect the running inference.

Reset
REQ-016 rst SHALL force IDLE immediately, including mid-inference, and set busy=0, valid=0, out=0, w_addr=0, acc=0, staging=0, j=i=0.
REQ-017 After rst is released, the first start SHALL run a full inference with no residue from an aborted one.

Configuration
REQ-018 With OUTPUT_LAYER_BIAS_EN defined, each neuron SHALL use N_IN+1 weight words at base j*(N_IN+1); word N_IN is a signed bias added to acc as bias <<< SHIFT before STORE.
REQ-019 With OUTPUT_LAYER_BIAS_EN defined, latency SHALL become N_OUT*(N_IN+2)+1.
REQ-020 Without OUTPUT_LAYER_BIAS_EN, no bias SHALL be fetched, base SHALL be j*N_IN, and the w_addr width SHALL be unchanged.

Structure
REQ-021 Shared package fnn_pkg SHALL hold DATA_W=8, N_OUT default, the state enum, and the sat function.
REQ-022 One sub-module mac_unit SHALL hold the signed 8x8 multiply, the accumulate/replace select and the acc register.

Verification
REQ-023 All weights 0, in_data any, start -> valid at cycle 171, out all zero, busy low after.
REQ-024 in_data all 64, every weight of neuron j = j -> out byte j = 8j (0,8,...,72).
REQ-025 in_data all 255, neuron 4 weights 127, others -128 -> byte 4 = 255 (saturated), others 0.
REQ-026 start pulsed every cycle during busy -> exactly one valid per 171 cycles, out unchanged mid-run.
REQ-027 rst asserted at cycle 50 of an inference -> out=0, busy=0 at once; next start gives correct result at +171.
REQ-028 With OUTPUT_LAYER_BIAS_EN, weights 0, bias of neuron 2 = 5 -> byte 2 = 5, others 0, valid at cycle 181.
